// File: rtl/weight_block.sv
// weight_block: delay-and-sum DOA estimator; steers NBEAMS beams over one FFT bin of a
// 4-mic array and reports the strongest beam index and its angle in degrees.
module weight_block #(
  parameter int PHASE_K = 448,
  parameter int NBEAMS  = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        detectdone,
  input  logic [9:0]  maxbin,
  input  logic [27:0] ramq1,
  input  logic [27:0] ramq2,
  input  logic [27:0] ramq3,
  input  logic [27:0] ramq4,
  output logic [9:0]  rdaddr2,
  output logic [9:0]  rdaddr3,
  output logic [9:0]  rdaddr4,
  output logic        done,
  output logic [3:0]  bnum,
  output logic [7:0]  doa
);
  localparam logic [3:0] S_IDLE = 4'd0, S_WAIT = 4'd1, S_CAP = 4'd2, S_MAC0 = 4'd3,
                         S_MAC1 = 4'd4, S_MAC2 = 4'd5, S_MAC3 = 4'd6, S_PWR = 4'd7,
                         S_CMP = 4'd8, S_DONE = 4'd9;
  // quarter-wave of round(16384*sin(2*pi*i/256)), i = 0..64
  localparam logic [14:0] QS [65] = '{
    15'd0,     15'd402,   15'd804,   15'd1205,  15'd1606,  15'd2006,  15'd2404,  15'd2801,
    15'd3196,  15'd3590,  15'd3981,  15'd4370,  15'd4756,  15'd5139,  15'd5520,  15'd5897,
    15'd6270,  15'd6639,  15'd7005,  15'd7366,  15'd7723,  15'd8076,  15'd8423,  15'd8765,
    15'd9102,  15'd9434,  15'd9760,  15'd10080, 15'd10394, 15'd10702, 15'd11003, 15'd11297,
    15'd11585, 15'd11866, 15'd12140, 15'd12406, 15'd12665, 15'd12916, 15'd13160, 15'd13395,
    15'd13623, 15'd13842, 15'd14053, 15'd14256, 15'd14449, 15'd14635, 15'd14811, 15'd14978,
    15'd15137, 15'd15286, 15'd15426, 15'd15557, 15'd15679, 15'd15791, 15'd15893, 15'd15986,
    15'd16069, 15'd16143, 15'd16207, 15'd16261, 15'd16305, 15'd16340, 15'd16364, 15'd16379,
    15'd16384
  };
  // 65536*sin(15*d degrees), d = 0..6
  localparam int SIN16 [7] = '{0, 16962, 32768, 46341, 56756, 63303, 65536};

  function automatic logic signed [15:0] sin8(input logic [7:0] i);
    logic [6:0] r;
    r = i[6] ? 7'd64 - {1'b0, i[5:0]} : {1'b0, i[5:0]};
    return i[7] ? -signed'({1'b0, QS[r]}) : signed'({1'b0, QS[r]});
  endfunction

  function automatic logic [15:0] k_of(input logic [3:0] b);
    logic [2:0] d;
    int m;
    d = b < 4'd6 ? 3'(4'd6 - b) : 3'(b - 4'd6);
    m = (PHASE_K * SIN16[d] + 32768) >>> 16;
    return b < 4'd6 ? 16'(-m) : 16'(m);
  endfunction

  logic [3:0]         r_state, w_next;
  logic [9:0]         r_bin;
  logic [3:0]         r_beam, r_bidx, r_bnum;
  logic [7:0]         r_doa;
  logic               r_done;
  logic [27:0]        r_x [4];
  logic signed [19:0] r_re, r_im;
  logic [39:0]        r_pwr, r_best;
  logic               w_start, w_cap, w_mac, w_pwr, w_cmp, w_fin;
  logic [1:0]         w_m;
  logic [15:0]        w_phase;
  logic signed [15:0] w_c, w_s;
  logic signed [31:0] w_a, w_b, w_cx, w_sx, w_re_t, w_im_t;
  logic signed [39:0] w_re_x, w_im_x;

  assign w_m     = 2'(r_state - S_MAC0);
  assign w_phase = 16'({6'd0, r_bin} * {14'd0, w_m} * k_of(r_beam));
  assign w_s     = sin8(w_phase[15:8]);
  assign w_c     = sin8(w_phase[15:8] + 8'd64);
  assign w_a     = 32'(signed'(r_x[w_m][27:14]));
  assign w_b     = 32'(signed'(r_x[w_m][13:0]));
  assign w_cx    = 32'(w_c);
  assign w_sx    = 32'(w_s);
  assign w_re_t  = w_a * w_cx - w_b * w_sx;
  assign w_im_t  = w_a * w_sx + w_b * w_cx;
  assign w_re_x  = 40'(r_re);
  assign w_im_x  = 40'(r_im);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    unique case (r_state)
      S_IDLE:  w_next = detectdone ? S_WAIT : S_IDLE;
      S_WAIT:  w_next = S_CAP;
      S_CAP:   w_next = S_MAC0;
      S_MAC0:  w_next = S_MAC1;
      S_MAC1:  w_next = S_MAC2;
      S_MAC2:  w_next = S_MAC3;
      S_MAC3:  w_next = S_PWR;
      S_PWR:   w_next = S_CMP;
      S_CMP:   w_next = r_beam < 4'(NBEAMS - 1) ? S_MAC0 : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start = r_state == S_IDLE && detectdone;
    w_cap   = r_state == S_CAP;
    w_mac   = r_state >= S_MAC0 && r_state <= S_MAC3;
    w_pwr   = r_state == S_PWR;
    w_cmp   = r_state == S_CMP;
    w_fin   = r_state == S_DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_beam <= '0;
      r_bidx <= '0;
      r_bnum <= '0;
      r_doa  <= '0;
      r_done <= 1'b0;
      r_re   <= '0;
      r_im   <= '0;
      r_pwr  <= '0;
      r_best <= '0;
      r_x    <= '{default: '0};
    end else begin
      r_done <= w_fin;
      if (w_start) begin
        r_bin  <= maxbin;
        r_best <= '0;
        r_bidx <= '0;
        r_beam <= '0;
      end
      if (w_cap) r_x <= '{ramq1, ramq2, ramq3, ramq4};
      // MAC0 restarts the accumulation for a new beam
      if (w_mac) begin
        r_re <= (w_m == 2'd0 ? 20'sd0 : r_re) + 20'(w_re_t >>> 14);
        r_im <= (w_m == 2'd0 ? 20'sd0 : r_im) + 20'(w_im_t >>> 14);
      end
      if (w_pwr) r_pwr <= 40'(w_re_x * w_re_x + w_im_x * w_im_x);
      if (w_cmp) begin
        if (r_pwr > r_best) begin
          r_best <= r_pwr;
          r_bidx <= r_beam;
        end
        if (r_beam < 4'(NBEAMS - 1)) r_beam <= r_beam + 4'd1;
      end
      if (w_fin) begin
        r_bnum <= r_bidx;
        r_doa  <= {4'd0, r_bidx} * 8'd15 - 8'd90;
      end
    end
  end

  assign rdaddr2 = r_bin;
  assign rdaddr3 = r_bin;
  assign rdaddr4 = r_bin;
  assign done    = r_done;
  assign bnum    = r_bnum;
  assign doa     = r_doa;
endmodule

// File: tb/tb_weight_block.sv
// tb_weight_block: directed runs of weight_block with a scoreboard checking each done pulse.
module tb_weight_block;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        detectdone = 1'b0;
  logic [9:0]  maxbin = '0;
  logic [27:0] q1, q2, q3, q4;
  logic [9:0]  rdaddr2, rdaddr3, rdaddr4;
  logic        done;
  logic [3:0]  bnum;
  logic [7:0]  doa;
  logic [27:0] mem [4][1024];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0] b;
    logic [7:0] d;
    int         t0;
  } exp_t;
  exp_t sb[$];

  weight_block dut (
    .clk(clk), .reset(reset), .detectdone(detectdone), .maxbin(maxbin),
    .ramq1(q1), .ramq2(q2), .ramq3(q3), .ramq4(q4),
    .rdaddr2(rdaddr2), .rdaddr3(rdaddr3), .rdaddr4(rdaddr4),
    .done(done), .bnum(bnum), .doa(doa)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // registered-read FFT RAMs; ram1 is addressed directly by maxbin
  always @(posedge clk) begin
    q1 <= mem[0][maxbin];
    q2 <= mem[1][rdaddr2];
    q3 <= mem[2][rdaddr3];
    q4 <= mem[3][rdaddr4];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d bnum %0d doa %0h", cyc, bnum, doa);
      end else begin
        e = sb.pop_front();
        chk("bnum", 32'(bnum), 32'(e.b));
        chk("doa", 32'(doa), 32'(e.d));
        chk("latency", cyc - e.t0, 81);
      end
    end
  end

  task automatic start(input logic [9:0] bin, input logic push, input logic [3:0] eb,
                       input logic [7:0] ed, output int t0);
    @(negedge clk);
    maxbin = bin;
    detectdone = 1'b1;
    @(negedge clk);
    detectdone = 1'b0;
    t0 = cyc;
    if (push) sb.push_back('{b: eb, d: ed, t0: t0});
    chk("rdaddr2", 32'(rdaddr2), 32'(bin));
    chk("rdaddr3", 32'(rdaddr3), 32'(bin));
    chk("rdaddr4", 32'(rdaddr4), 32'(bin));
  endtask

  task automatic drain();
    for (int i = 0; i < 120 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_timeout pending %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic fill44(input int re, input int im);
    for (int m = 0; m < 4; m++) mem[m][44] = {14'(re), 14'(im)};
  endtask

  initial begin
    int t0;
    int phi;
    real ang;
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 1024; a++) mem[m][a] = {14'(a * 7 + m * 100 - 3000), 14'(a * 3 - 1500)};
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_bnum", 32'(bnum), 0);
    chk("rst_doa", 32'(doa), 0);
    chk("rst_rdaddr2", 32'(rdaddr2), 0);
    reset = 1'b0;

    fill44(0, 0);
    start(10'd44, 1'b1, 4'd0, 8'hA6, t0);
    drain();

    fill44(500, -300);
    start(10'd44, 1'b1, 4'd6, 8'h00, t0);
    drain();
    repeat (10) @(negedge clk);
    chk("hold_bnum", 32'(bnum), 6);
    chk("hold_doa", 32'(doa), 0);
    chk("hold_done", 32'(done), 0);

    // plane wave from 60 degrees: K = 388 at bin 44
    for (int m = 0; m < 4; m++) begin
      phi = (m * 44 * 388) % 65536;
      ang = 6.283185307179586 * real'(phi) / 65536.0;
      mem[m][44] = {14'(int'(400.0 * $cos(ang))), 14'(int'(-400.0 * $sin(ang)))};
    end
    start(10'd44, 1'b1, 4'd10, 8'h3C, t0);
    drain();
    start(10'd44, 1'b1, 4'd10, 8'h3C, t0);
    drain();

    start(10'd44, 1'b1, 4'd10, 8'h3C, t0);
    repeat (19) @(negedge clk);
    detectdone = 1'b1;
    @(negedge clk);
    detectdone = 1'b0;
    drain();
    repeat (30) @(negedge clk);

    fill44(500, -300);
    start(10'd44, 1'b0, 4'd0, 8'h00, t0);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_done", 32'(done), 0);
    chk("abort_bnum", 32'(bnum), 0);
    chk("abort_doa", 32'(doa), 0);
    chk("abort_rdaddr2", 32'(rdaddr2), 0);
    start(10'd44, 1'b1, 4'd6, 8'h00, t0);
    drain();
    repeat (100) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
